mfi_retire_packer: RTL

- Converts the core's raw per-instruction retirement events into ordered MFI packets for the formal checks.
- The core exports only the PC of each retiring instruction. This block holds each retirement until its successor retires, then emits it with mfi_pc_wdata set to the successor's PC.
- Assigns a monotonically increasing mfi_order to each packet.
- Generates the check strobe for the packet whose order matches a selected value.
- Sits between the core retire port and the mfi_* input bus of the check modules.

---
 rtl/mfi_retire_packer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mfi_retire_packer.sv
// Holds each retirement until its successor retires, then emits it as an ordered MFI packet.
// Latency: one edge after the successor (or one cycle after a halt); no backpressure, one packet per cycle max.
module mfi_retire_packer #(
    parameter int XLEN        = 32,
    parameter int ORDER_W     = 32,
    parameter int HALT_PC_INC = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ret_valid,
    input  logic [XLEN-1:0]    ret_pc,
    input  logic [31:0]        ret_insn,
    input  logic               ret_trap,
    input  logic               ret_halt,
    input  logic [ORDER_W-1:0] check_order,
    output logic               mfi_valid,
    output logic [ORDER_W-1:0] mfi_order,
    output logic [31:0]        mfi_insn,
    output logic [XLEN-1:0]    mfi_pc_rdata,
    output logic [XLEN-1:0]    mfi_pc_wdata,
    output logic               mfi_trap,
    output logic               mfi_halt,
    output logic               check,
    output logic               proto_err
);

    localparam logic [XLEN-1:0] HALT_INC = XLEN'(HALT_PC_INC);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_HOLD,
        S_HALT_PEND,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [XLEN-1:0]    slot_pc;
    logic [31:0]        slot_insn;
    logic               slot_trap;
    logic [ORDER_W-1:0] ord_cnt;

    logic               load;
    logic               emit;
    logic [XLEN-1:0]    emit_wdata;
    logic               emit_halt;
    logic               err_set;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        emit       = 1'b0;
        emit_wdata = '0;
        emit_halt  = 1'b0;
        err_set    = 1'b0;
        case (state)
            S_EMPTY: begin
                if (ret_valid) begin
                    load      = 1'b1;
                    state_nxt = ret_halt ? S_HALT_PEND : S_HOLD;
                end
            end
            S_HOLD: begin
                if (ret_valid) begin
                    emit       = 1'b1;
                    emit_wdata = ret_pc;
                    load       = 1'b1;
                    state_nxt  = ret_halt ? S_HALT_PEND : S_HOLD;
                end
            end
            S_HALT_PEND: begin
                // The halt has no successor, so its next PC is synthesised.
                emit       = 1'b1;
                emit_wdata = slot_pc + HALT_INC;
                emit_halt  = 1'b1;
                state_nxt  = S_DONE;
                err_set    = ret_valid;
            end
            S_DONE: begin
                err_set = ret_valid;
            end
            default: begin
                state_nxt = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot_pc   <= '0;
            slot_insn <= '0;
            slot_trap <= 1'b0;
        end else if (load) begin
            slot_pc   <= ret_pc;
            slot_insn <= ret_insn;
            slot_trap <= ret_trap;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ord_cnt      <= '0;
            mfi_valid    <= 1'b0;
            mfi_order    <= '0;
            mfi_insn     <= '0;
            mfi_pc_rdata <= '0;
            mfi_pc_wdata <= '0;
            mfi_trap     <= 1'b0;
            mfi_halt     <= 1'b0;
            check        <= 1'b0;
        end else if (emit) begin
            ord_cnt      <= ord_cnt + 1'b1;
            mfi_valid    <= 1'b1;
            mfi_order    <= ord_cnt;
            mfi_insn     <= slot_insn;
            mfi_pc_rdata <= slot_pc;
            mfi_pc_wdata <= emit_wdata;
            mfi_trap     <= slot_trap;
            mfi_halt     <= emit_halt;
            check        <= (ord_cnt == check_order);
        end else begin
            // Data fields keep the last packet; only the strobes drop.
            mfi_valid <= 1'b0;
            check     <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            proto_err <= 1'b0;
        end else if (err_set) begin
            proto_err <= 1'b1;
        end
    end

endmodule
